// File: rtl/params_pkg.sv
// Shared datapath width for the modular-arithmetic blocks.
package params_pkg;
  localparam int DATA_LENGTH = 32;
endpackage

// File: rtl/montgomery_digit_serial.sv
// Digit-serial Montgomery multiplier: result = x*y*R^-1 mod m, R = 2^(DIGIT_W*N), N = ceil(m_bl/DIGIT_W).
// Define MONT_FINAL_SUB_EN to add the final conditional subtraction; otherwise result is lazily reduced to [0,2m).
module montgomery_digit_serial #(
  parameter int DATA_LENGTH = params_pkg::DATA_LENGTH,
  parameter int DIGIT_W     = 2,
  parameter int BL_W        = $clog2(DATA_LENGTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   ready_o,
  output logic                   busy_o,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] y_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [BL_W-1:0]        m_bl_i,
  input  logic [DIGIT_W-1:0]     m_prime_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  input  logic                   ready_i
);
  localparam int AW = DATA_LENGTH + DIGIT_W + 1;
  localparam int SW = AW + 1;

  typedef enum logic [1:0] {IDLE, CALC, SUB, DONE} state_e;
  state_e state_q, state_d;

  logic [DATA_LENGTH-1:0] x_q, y_q, m_q, res_q;
  logic [DIGIT_W-1:0]     mp_q;
  logic [AW-1:0]          a_q, a_d;
  logic [BL_W-1:0]        cnt_q, nm1_q;

  // Iteration count: bit length forced into [1, DATA_LENGTH], then ceil-divided by the digit width.
  logic [BL_W-1:0] bl_c, n_m1_c;
  logic [BL_W:0]   bl_sum;
  always_comb begin
    bl_c = m_bl_i;
    if (m_bl_i == '0)
      bl_c = BL_W'(1);
    else if (int'(m_bl_i) > DATA_LENGTH)
      bl_c = BL_W'(DATA_LENGTH);
  end
  assign bl_sum = {1'b0, bl_c} + (BL_W+1)'(DIGIT_W - 1);
  assign n_m1_c = BL_W'(bl_sum / (BL_W+1)'(DIGIT_W)) - BL_W'(1);

  // One Montgomery step; x_q is shifted down each cycle so its low digit is always the current one.
  logic [DIGIT_W-1:0] d_c, t_lo, q_c;
  logic [SW-1:0]      dy_c;
  logic               last_c;
  assign d_c    = x_q[DIGIT_W-1:0];
  assign dy_c   = SW'(d_c) * SW'(y_q);
  assign t_lo   = a_q[DIGIT_W-1:0] + dy_c[DIGIT_W-1:0];
  assign q_c    = t_lo * mp_q;
  assign a_d    = AW'((SW'(a_q) + dy_c + SW'(q_c) * SW'(m_q)) >> DIGIT_W);
  assign last_c = (cnt_q == nm1_q);

`ifdef MONT_FINAL_SUB_EN
  // A < 2m, so A - m fits in DATA_LENGTH bits whenever it is taken.
  logic                   ge_c;
  logic [DATA_LENGTH-1:0] res_d;
  assign ge_c  = (a_q >= AW'(m_q));
  assign res_d = ge_c ? (a_q[DATA_LENGTH-1:0] - m_q) : a_q[DATA_LENGTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = CALC;
      CALC: if (last_c) begin
`ifdef MONT_FINAL_SUB_EN
        state_d = SUB;
`else
        state_d = DONE;
`endif
      end
      SUB:  state_d = DONE;
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      m_q     <= '0;
      mp_q    <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      nm1_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (start_i) begin
          x_q   <= x_i;
          y_q   <= y_i;
          m_q   <= m_i;
          mp_q  <= m_prime_i;
          a_q   <= '0;
          cnt_q <= '0;
          nm1_q <= n_m1_c;
        end
        CALC: begin
          a_q   <= a_d;
          x_q   <= x_q >> DIGIT_W;
          cnt_q <= cnt_q + BL_W'(1);
`ifndef MONT_FINAL_SUB_EN
          if (last_c) res_q <= a_d[DATA_LENGTH-1:0];
`endif
        end
`ifdef MONT_FINAL_SUB_EN
        SUB: res_q <= res_d;
`endif
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == CALC) || (state_q == SUB);
  assign valid_o  = (state_q == DONE);
  assign result_o = res_q;
endmodule

// File: tb/tb_montgomery_digit_serial.sv
// Bench for montgomery_digit_serial: hand vectors, handshake/reset sequences and random ops vs. a modular-arithmetic model.
module tb_montgomery_digit_serial;
  localparam int DL = 32;
`ifdef MONT_FINAL_SUB_EN
  localparam int LAT_ADD = 2;
`else
  localparam int LAT_ADD = 1;
`endif

  logic gclk = 1'b0;
  logic rst_n;
  logic start2, start1, ready_i;
  logic [DL-1:0] x, y, m;
  logic [5:0] bl;
  logic [1:0] mp2;
  logic [0:0] mp1;
  logic rdy2, bsy2, vld2, rdy1, bsy1, vld1;
  logic [DL-1:0] res2, res1;
  int checks = 0;
  int failures = 0;

  always #5 gclk = ~gclk;

  montgomery_digit_serial #(.DATA_LENGTH(DL), .DIGIT_W(2)) dut (
    .clk_i(gclk), .rst_ni(rst_n), .start_i(start2), .ready_o(rdy2), .busy_o(bsy2),
    .x_i(x), .y_i(y), .m_i(m), .m_bl_i(bl), .m_prime_i(mp2),
    .result_o(res2), .valid_o(vld2), .ready_i(ready_i));

  montgomery_digit_serial #(.DATA_LENGTH(DL), .DIGIT_W(1)) dut1 (
    .clk_i(gclk), .rst_ni(rst_n), .start_i(start1), .ready_o(rdy1), .busy_o(bsy1),
    .x_i(x), .y_i(y), .m_i(m), .m_bl_i(bl), .m_prime_i(mp1),
    .result_o(res1), .valid_o(vld1), .ready_i(ready_i));

  typedef struct {
    logic [31:0] x, y, m;
    logic [5:0]  b;
    int          n;
    logic [31:0] r;
  } vec_t;

  function automatic int n_of(int b, int d);
    int c;
    c = b;
    if (c == 0) c = 1;
    if (c > DL) c = DL;
    return (c + d - 1) / d;
  endfunction

  // x*y*2^-k mod m, with 2^-1 = (m+1)/2 for odd m
  function automatic longint unsigned mont_ref(longint unsigned a, longint unsigned b,
                                               longint unsigned mm, int k);
    longint unsigned rinv, p;
    rinv = (mm + 1) / 2;
    p = (a * b) % mm;
    for (int i = 0; i < k; i++) p = (p * rinv) % mm;
    return p;
  endfunction

  function automatic logic [7:0] mprime(longint unsigned mm, int d);
    longint unsigned md;
    md = 64'd1 << d;
    for (longint unsigned v = 0; v < md; v++)
      if ((mm * v + 1) % md == 0) return 8'(v);
    return 8'd0;
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input longint unsigned r, input longint unsigned er,
                         input longint unsigned mm);
`ifdef MONT_FINAL_SUB_EN
    chk({nm, "_res"}, r, er);
`else
    chk({nm, "_resmod"}, r % mm, er);
    chk({nm, "_below2m"}, longint'(r < 2 * mm), 1);
`endif
  endtask

  task automatic op(input bit sel, input logic [31:0] xa, input logic [31:0] ya,
                    input logic [31:0] ma, input logic [5:0] b,
                    input longint unsigned er, input int en, input string nm);
    int lat, bad;
    logic [31:0] r;
    logic [7:0] mpv;
    mpv = mprime(ma, sel ? 1 : 2);
    @(negedge gclk);
    x = xa; y = ya; m = ma; bl = b; mp2 = mpv[1:0]; mp1 = mpv[0:0];
    if (sel) start1 = 1'b1; else start2 = 1'b1;
    @(posedge gclk); #1;
    start1 = 1'b0; start2 = 1'b0;
    x = $urandom; y = $urandom; m = $urandom; bl = 6'($urandom);
    lat = 0; bad = 0;
    do begin
      @(negedge gclk); lat++;
      if (sel ? (!$onehot({rdy1, bsy1, vld1}) || rdy1) : (!$onehot({rdy2, bsy2, vld2}) || rdy2)) bad++;
    end while (!(sel ? vld1 : vld2) && lat < 200);
    r = sel ? res1 : res2;
    chk({nm, "_lat"}, lat, en + LAT_ADD);
    chk_res(nm, r, er, ma);
    chk({nm, "_flags"}, bad, 0);
    @(negedge gclk);
    chk({nm, "_idle"}, sel ? rdy1 : rdy2, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];
  int w, n, lat, bad, sel;
  logic [31:0] mm, xx, yy, mask, r;
  longint unsigned e;

  initial begin
    tbl[0] = '{32'd3,         32'h3FFE, 32'h7FE001,   6'd23, 12, 32'd0};
    tbl[0] = '{32'd3,         32'd14,   32'd17,       6'd5,  3,  32'd15};
    tbl[1] = '{32'd1,         32'h3FFE, 32'h7FE001,   6'd23, 12, 32'd1};
    tbl[2] = '{32'd0,         32'h1234, 32'h7FE001,   6'd23, 12, 32'd0};
    tbl[3] = '{32'h1234,      32'd0,    32'h7FE001,   6'd23, 12, 32'd0};
    tbl[4] = '{32'd2,         32'd1,    32'd3,        6'd0,  1,  32'd2};
    tbl[5] = '{32'd1,         32'd2,    32'h7FFFFFFF, 6'd40, 16, 32'd1};
    tbl[6] = '{32'd16,        32'd16,   32'd17,       6'd5,  3,  32'd4};

    rst_n = 1'b0; ready_i = 1'b1; start1 = 1'b0; start2 = 1'b0;
    x = '0; y = '0; m = '0; bl = '0; mp2 = '0; mp1 = '0;
    repeat (2) @(posedge gclk);
    #1 rst_n = 1'b1;
    @(negedge gclk);
    chk("rst_ready", rdy2, 1);
    chk("rst_busy", bsy2, 0);
    chk("rst_valid", vld2, 0);
    chk("rst_result", res2, 0);

    foreach (tbl[i]) op(1'b0, tbl[i].x, tbl[i].y, tbl[i].m, tbl[i].b, tbl[i].r, tbl[i].n, $sformatf("vec%0d", i));
    op(1'b1, 32'd3, 32'd14, 32'd17, 6'd5, 13, 5, "dw1_case1");

    // Handshake: result held under backpressure, starts in CALC and DONE ignored
    ready_i = 1'b0;
    @(negedge gclk);
    x = 32'd3; y = 32'd14; m = 32'd17; bl = 6'd5; mp2 = 2'd3; start2 = 1'b1;
    @(posedge gclk); #1 start2 = 1'b0;
    @(negedge gclk);
    x = 32'd9; start2 = 1'b1;
    @(negedge gclk);
    start2 = 1'b0;
    lat = 2;
    while (!vld2 && lat < 200) begin @(negedge gclk); lat++; end
    chk("hs_lat", lat, 3 + LAT_ADD);
    chk("hs_res", res2, 15);
    r = res2;
    for (int k = 0; k < 10; k++) begin
      @(negedge gclk);
      start2 = (k == 3);
      chk("hs_hold", longint'(vld2 && !rdy2 && res2 == r), 1);
    end
    start2 = 1'b0;
    ready_i = 1'b1;
    @(negedge gclk);
    chk("hs_release", longint'(rdy2 && !vld2), 1);
    bad = 0;
    repeat (8) begin @(negedge gclk); if (vld2 || !rdy2) bad++; end
    chk("hs_no_extra", bad, 0);

    // Reset during CALC after four iterations
    @(negedge gclk);
    x = 32'd1; y = 32'h3FFE; m = 32'h7FE001; bl = 6'd23; mp2 = 2'd3; start2 = 1'b1;
    @(posedge gclk); #1 start2 = 1'b0;
    repeat (4) @(posedge gclk);
    @(negedge gclk); rst_n = 1'b0;
    @(posedge gclk); #1 rst_n = 1'b1;
    @(negedge gclk);
    chk("mid_rst_ready", rdy2, 1);
    chk("mid_rst_busy", bsy2, 0);
    chk("mid_rst_valid", vld2, 0);
    chk("mid_rst_result", res2, 0);
    op(1'b0, 32'd3, 32'd14, 32'd17, 6'd5, 15, 3, "after_rst");

    // Random operands against the model, both digit widths
    for (int k = 0; k < 24; k++) begin
      w = $urandom_range(2, 31);
      mask = (32'd1 << w) - 32'd1;
      mm = ($urandom & mask) | (32'd1 << (w - 1)) | 32'd1;
      xx = $urandom % mm;
      yy = $urandom % mm;
      sel = (k % 4 == 3) ? 1 : 0;
      n = n_of(w, sel ? 1 : 2);
      e = mont_ref(xx, yy, mm, (sel ? 1 : 2) * n);
      op(sel[0], xx, yy, mm, 6'(w), e, n, sel ? "rand_dw1" : "rand_dw2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/montgomery_digit_serial.md
# montgomery_digit_serial

Parametrised digit-serial Montgomery multiplier, the successor to the bit-serial `montgomery_serialized` core. It computes `x * y * R^-1 mod m` with `R = 2^(DIGIT_W*N)` and `N = ceil(m_bl/DIGIT_W)`, consuming `DIGIT_W` bits of `x` per cycle. It adds a ready/valid output handshake and a compile-time optional final subtraction. It sits in the modular-arithmetic datapath, for example NTT butterflies for the Dilithium modulus, with operands already in Montgomery form where required.

## Interface

**Parameters**
- `DATA_LENGTH`, default `params_pkg::DATA_LENGTH`: operand and modulus width in bits.
- `DIGIT_W`, default 2: bits of `x` processed per iteration. Legal range 1..8; must be `<= DATA_LENGTH`.
- `BL_W`, default `$clog2(DATA_LENGTH+1)`: width of `m_bl_i`.

**Ports**
- `clk_i` in 1: rising-edge clock; the only clock.
- `rst_ni` in 1: reset, **synchronous, active-low**.
- `start_i` in 1: start request; sampled only in IDLE.
- `ready_o` in→out 1: high in IDLE (operands may be presented).
- `busy_o` out 1: high in CALC and SUB.
- `x_i` in DATA_LENGTH: multiplicand; must satisfy `x < m`.
- `y_i` in DATA_LENGTH: multiplier, normally in Montgomery form; must satisfy `y < m`.
- `m_i` in DATA_LENGTH: odd modulus.
- `m_bl_i` in BL_W: modulus bit length.
- `m_prime_i` in DIGIT_W: `-m^-1 mod 2^DIGIT_W`, supplied by the caller.
- `result_o` out DATA_LENGTH: product; stable while `valid_o` is high.
- `valid_o` out 1: result available; held until accepted.
- `ready_i` in 1: downstream accepts the result.

## Operation

**FSM states**
- IDLE → CALC on `start_i`. In the same edge, `x`, `y`, `m`, `m'` are latched, the accumulator `A` is cleared, the digit counter is set to 0, and `N` is latched.
- CALC, one iteration per cycle, with `i` the digit counter:
  - `d = x[DIGIT_W*i +: DIGIT_W]`
  - `q = ((A + d*y) * m') mod 2^DIGIT_W`
  - `A = (A + d*y + q*m) >> DIGIT_W`
  - Implement the low-digit product with the latched `x` shifted right by `DIGIT_W` each cycle; no indexed mux.
  - After the iteration with `i = N-1`, go to SUB (or DONE, see Configuration).
- SUB: if `A >= m`, then `result = A - m`, otherwise `result = A`. Go to DONE.
- DONE: `valid_o = 1`. When `ready_i = 1`, go to IDLE. `result_o` holds its value until the next accepted start.

**Arithmetic**
- Accumulator width is `DATA_LENGTH + DIGIT_W + 1`. No overflow is permitted.
- Invariant: `A < 2m` at every iteration boundary, given `x, y < m`.
- `N = ceil(m_bl/DIGIT_W)`.
- `m_bl_i = 0` is treated as 1.
- `m_bl_i > DATA_LENGTH` is clamped to `DATA_LENGTH`.

**Boundary conditions**
- `start_i` outside IDLE is ignored; no queuing.
- Input ports are don't-care after the start edge.
- `ready_i` outside DONE has no effect.
- Reset asserted in any state: on the next edge, go to IDLE, abort the computation, and return all outputs to their reset values.
- `x = 0` or `y = 0` gives `result = 0`, with the full latency.

## Timing

**Reset values**
- `ready_o = 1`
- `busy_o = 0`
- `valid_o = 0`
- `result_o = 0`
- FSM in IDLE.

**Latency**
- Start edge at cycle 0.
- CALC occupies the N edges 1..N.
- SUB is edge N+1.
- `valid_o` is high from cycle N+2 (N+1 without the final subtraction).

**Throughput**
- One operation per N+3 cycles when `ready_i` is held high.
- DONE→IDLE takes 1 edge; the next start is sampled the cycle after.

**Signal relationships**
- `ready_o` is high only in IDLE.
- `ready_o`, `busy_o` and `valid_o` are mutually exclusive.

## Configuration

- `MONT_FINAL_SUB_EN` defined:
  - The SUB state is present.
  - `result_o` is in `[0, m)`.
  - Latency is N+2.
- `MONT_FINAL_SUB_EN` undefined (lazy reduction):
  - The SUB state and the comparator are removed; CALC goes directly to DONE.
  - `result_o = A`, which lies in `[0, 2m)` and is congruent to the exact result mod `m`.
  - Latency is N+1.
  - Callers chaining multiplications must allow inputs below `2m`. The `A < 2m` guarantee for chained use holds only when `4m < R`.

## Test plan

1. `DIGIT_W=2`, `m=17`, `m_bl=5`, `m'=3`, `x=3`, `y=14` (that is, `5*64 mod 17`) → `result_o = 15`. With `MONT_FINAL_SUB_EN` defined, `valid_o` rises 5 cycles after the start edge.
2. Dilithium: `m = 0x7FE001`, `m_bl = 23`, `DIGIT_W = 2` (N = 12), `m' = 3`, `x = 1`, `y = 0x003FFE` (`R mod q`) → `result_o = 0x000001`, latency 14. Then sweep the file `input_dilithium_mont.txt` and check every entry against `x*y mod m`.
3. Handshake: hold `ready_i = 0` for 10 cycles in DONE → `valid_o` and `result_o` stay stable. Pulse `start_i` during CALC and during DONE → ignored, with no extra result produced.
4. Reset mid-operation: drive `rst_ni = 0` for 1 cycle during CALC (i = 4) → on the next edge `ready_o = 1`, `valid_o = 0`, `result_o = 0`. A subsequent start of case 1 returns 15.
5. Edges:
   - `x = 0` → `result_o = 0` with full latency.
   - `m_bl_i = 0` → completes with N = 1.
   - `m_bl_i = 40` with `DATA_LENGTH = 32` → clamped, N = 16.
   - `DIGIT_W = 1` reproduces the bit-serial results.
6. Without `MONT_FINAL_SUB_EN`: `m = 17`, `x = 16`, `y = 16`, `DIGIT_W = 2` → `result_o < 34` and `result_o mod 17 = 16*16*64^-1 mod 17`. `valid_o` rises 4 cycles after the start edge.
